// File: rtl/mips_muldiv_unit.sv
// HI/LO owner for the MIPS execute stage: 32-step shift-add multiplier and
// restoring divider plus MTHI/MTLO/MFHI/MFLO, interlocked by op_valid/op_ready.
module mips_muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        op_ready,
   output logic        busy,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        div_by_zero
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MFHI  = 3'b110;
   localparam logic [2:0] OP_MFLO  = 3'b111;

   function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
      return en ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
      return en ? (~v + 64'd1) : v;
   endfunction

   logic [1:0]  r_state;
   logic [5:0]  r_cnt;
   logic [63:0] r_acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
   logic [31:0] r_opnd;      // multiplicand or divisor magnitude
   logic        r_is_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_rd_data;
   logic        r_rd_valid;
   logic        r_dbz;

   logic        w_accept;
   logic        w_signed;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [32:0] w_mul_sum;
   logic [32:0] w_rem_sh;
   logic        w_fits;
   logic [31:0] w_diff;
   logic [63:0] w_step;
   logic [63:0] w_prod;

   assign op_ready    = (r_state == ST_IDLE) & ~reset;
   assign busy        = (r_state != ST_IDLE);
   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_data;
   assign div_by_zero = r_dbz;

   assign w_accept = op_valid & op_ready;
   assign w_signed = ~op[0];
   assign w_mag_a  = neg32(src_a, w_signed & src_a[31]);
   assign w_mag_b  = neg32(src_b, w_signed & src_b[31]);
   assign w_prod   = neg64(r_acc, r_neg_q);

   // One iteration step of either the multiplier or the restoring divider
   always_comb begin
      w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
      w_rem_sh  = r_acc[63:31];
      w_fits    = (w_rem_sh >= {1'b0, r_opnd});
      w_diff    = w_rem_sh[31:0] - r_opnd;
      if (r_is_div) begin
         if (w_fits) begin
            w_step = {w_diff, r_acc[30:0], 1'b1};
         end else begin
            w_step = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
         end
      end else begin
         w_step = {w_mul_sum, r_acc[31:1]};
      end
   end

   // Sequencer state, HI/LO registers and registered result pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 6'd0;
         r_acc      <= 64'd0;
         r_opnd     <= 32'd0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_rd_data  <= 32'd0;
         r_rd_valid <= 1'b0;
         r_dbz      <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_dbz      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        if (op[1] && (src_b == 32'd0)) begin
                           r_dbz <= 1'b1;
                        end else begin
                           r_is_div <= op[1];
                           r_neg_q  <= w_signed & (src_a[31] ^ src_b[31]);
                           r_neg_r  <= w_signed & op[1] & src_a[31];
                           r_opnd   <= op[1] ? w_mag_b : w_mag_a;
                           r_acc    <= {32'd0, op[1] ? w_mag_a : w_mag_b};
                           r_cnt    <= 6'd0;
                           r_state  <= ST_ITER;
                        end
                     end
                     OP_MTHI: r_hi <= src_a;
                     OP_MTLO: r_lo <= src_a;
                     OP_MFHI: begin
                        r_rd_data  <= r_hi;
                        r_rd_valid <= 1'b1;
                     end
                     OP_MFLO: begin
                        r_rd_data  <= r_lo;
                        r_rd_valid <= 1'b1;
                     end
                     default: r_state <= ST_IDLE;
                  endcase
               end
            end
            ST_ITER: begin
               r_acc <= w_step;
               if (r_cnt == 6'd31) begin
                  r_state <= ST_FIX;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            ST_FIX: begin
               if (r_is_div) begin
                  r_lo <= neg32(r_acc[31:0], r_neg_q);
                  r_hi <= neg32(r_acc[63:32], r_neg_r);
               end else begin
                  r_lo <= w_prod[31:0];
                  r_hi <= w_prod[63:32];
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases plus random
// mul/div/MT traffic compared against a 64-bit arithmetic model of HI/LO.
module tb_mips_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        op_ready;
   logic        busy;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        div_by_zero;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   always #5 clk = ~clk;

   mips_muldiv_unit dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .src_a(src_a), .src_b(src_b), .op_ready(op_ready), .busy(busy),
      .rd_valid(rd_valid), .rd_data(rd_data), .div_by_zero(div_by_zero)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: HI/LO after an arithmetic op, from plain 64-bit arithmetic
   task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sp, sq, sr;
      logic [63:0] up, uq, ur;
      case (o)
         3'd0: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            m_hi = sp[63:32]; m_lo = sp[31:0];
         end
         3'd1: begin
            up = {32'd0, a} * {32'd0, b};
            m_hi = up[63:32]; m_lo = up[31:0];
         end
         3'd2: begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            m_lo = sq[31:0]; m_hi = sr[31:0];
         end
         default: begin
            uq = {32'd0, a} / {32'd0, b};
            ur = {32'd0, a} % {32'd0, b};
            m_lo = uq[31:0]; m_hi = ur[31:0];
         end
      endcase
   endtask

   // Present an op and hold it until accepted; returns 1ns after the accept edge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int n;
      op_valid = 1'b1; op = o; src_a = a; src_b = b;
      n = 0;
      while (!op_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept", {31'd0, op_ready}, 32'd1);
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic mf(input logic sel_hi);
      issue(sel_hi ? 3'd6 : 3'd7, $urandom, $urandom);
      chk("rd_valid", {31'd0, rd_valid}, 32'd1);
      chk(sel_hi ? "mfhi" : "mflo", rd_data, sel_hi ? m_hi : m_lo);
      @(posedge clk); #1;
      chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
   endtask

   task automatic mt(input logic sel_hi, input logic [31:0] v);
      issue(sel_hi ? 3'd4 : 3'd5, v, $urandom);
      if (sel_hi) m_hi = v;
      else        m_lo = v;
   endtask

   task automatic arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int n;
      issue(o, a, b);
      if (o[1] && b == 32'd0) begin
         chk("dbz_pulse", {31'd0, div_by_zero}, 32'd1);
         chk("dbz_busy", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
         chk("dbz_clear", {31'd0, div_by_zero}, 32'd0);
         chk("dbz_busy2", {31'd0, busy}, 32'd0);
      end else begin
         n = 0;
         while (busy && n < 60) begin
            n++;
            @(posedge clk); #1;
         end
         chk("busy_cycles", n, 32'd33);
         model(o, a, b);
      end
      mf(1'b1);
      mf(1'b0);
   endtask

   initial begin
      int n;
      logic [2:0]  o;
      logic [31:0] a, b;
      reset = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, op_ready}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, op_ready}, 32'd1);
      mf(1'b1);
      mf(1'b0);

      // Directed corner cases
      arith(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("multu_hi_const", m_hi, 32'hFFFFFFFE);
      arith(3'd0, 32'hFFFFFFFD, 32'd5);
      arith(3'd2, 32'hFFFFFFF9, 32'd2);
      arith(3'd3, 32'd100, 32'd7);
      arith(3'd2, 32'h80000000, 32'hFFFFFFFF);
      arith(3'd3, 32'd100, 32'd0);
      arith(3'd2, 32'h00000007, 32'd0);

      // MT followed immediately by MF
      mt(1'b1, 32'h12345678);
      mf(1'b1);
      mt(1'b0, 32'hCAFEF00D);
      mf(1'b0);

      // MFLO held while a MULT runs: accepted only once the result is in LO
      issue(3'd0, 32'h00012345, 32'hFFFF0003);
      model(3'd0, 32'h00012345, 32'hFFFF0003);
      op_valid = 1'b1; op = 3'd7;
      n = 0;
      while (!op_ready && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("held_mf_wait", n, 32'd33);
      @(posedge clk); #1;
      op_valid = 1'b0;
      chk("held_mf_valid", {31'd0, rd_valid}, 32'd1);
      chk("held_mf_data", rd_data, m_lo);

      // Reset in the middle of a MULT
      mt(1'b1, 32'hA5A5A5A5);
      mt(1'b0, 32'h5A5A5A5A);
      issue(3'd0, 32'h7FFFFFFF, 32'h00000003);
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, op_ready}, 32'd0);
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      mf(1'b1);
      mf(1'b0);

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFFFFFF;
            3:       a = 32'h80000000;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 4) == 0) begin
            mt($urandom_range(0, 1) == 1, a);
            mf(1'b1);
            mf(1'b0);
         end else begin
            o = 3'($urandom_range(0, 3));
            arith(o, a, b);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
